// File: rtl/div3_bcd_counter_if.sv
// Bus bundle for div3_bcd_counter: divider enable, control strobes, BCD load value and status pulses.
`timescale 1ns/1ps

interface div3_bcd_counter_if;
  logic       fdclk;
  logic       c_up;
  logic       clr;
  logic       load;
  logic [7:0] ld_val;
  logic [7:0] cnt;
  logic       tick;
  logic       wrap;
  logic       ld_err;

  modport master (
    output fdclk, c_up, clr, load, ld_val,
    input  cnt, tick, wrap, ld_err
  );

  modport slave (
    input  fdclk, c_up, clr, load, ld_val,
    output cnt, tick, wrap, ld_err
  );
endinterface

// File: rtl/div3_bcd_counter.sv
// Modulo-60 BCD up/down counter stepped by the rising edge of a divide-by-3 enable.
// Optional macro DIV3_CNT_SAT_EN: saturate at 59/00 instead of wrapping.
`timescale 1ns/1ps

module div3_bcd_counter (
  input  logic                  clk,
  input  logic                  rst_b,
  div3_bcd_counter_if.slave     bus
);

  logic       fdclk_q_reg;
  logic       step;
  logic [3:0] units_reg, units_next;
  logic [3:0] tens_reg, tens_next;
  logic       tick_reg, tick_next;
  logic       wrap_reg, wrap_next;
  logic       ld_err_reg, ld_err_next;

  logic [1:0] digit_ok;
  logic       ld_ok;
  logic [3:0] adj_units, adj_tens;
  logic       adj_wrap;

  assign step = bus.fdclk & ~fdclk_q_reg;

  // Digit 0 (units) may reach 9, digit 1 (tens) only 5.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit_chk
      localparam logic [3:0] DIGIT_MAX = (gi == 0) ? 4'd9 : 4'd5;
      assign digit_ok[gi] = (bus.ld_val[gi*4 +: 4] <= DIGIT_MAX);
    end
  endgenerate

  assign ld_ok = &digit_ok;

  // Candidate value one step away in the requested direction, with boundary flag.
  always_comb begin
    adj_units = units_reg;
    adj_tens  = tens_reg;
    adj_wrap  = 1'b0;
    if (bus.c_up) begin
      if (units_reg >= 4'd9) begin
        adj_units = 4'd0;
        if (tens_reg >= 4'd5) begin
          adj_tens = 4'd0;
          adj_wrap = 1'b1;
        end else begin
          adj_tens = tens_reg + 4'd1;
        end
      end else begin
        adj_units = units_reg + 4'd1;
      end
    end else begin
      if (units_reg == 4'd0) begin
        adj_units = 4'd9;
        if (tens_reg == 4'd0) begin
          adj_tens = 4'd5;
          adj_wrap = 1'b1;
        end else begin
          adj_tens = tens_reg - 4'd1;
        end
      end else begin
        adj_units = units_reg - 4'd1;
      end
    end
  end

  // clr beats load beats step; losers are dropped, not queued.
  always_comb begin
    units_next  = units_reg;
    tens_next   = tens_reg;
    tick_next   = 1'b0;
    wrap_next   = 1'b0;
    ld_err_next = 1'b0;
    if (bus.clr) begin
      units_next = 4'd0;
      tens_next  = 4'd0;
    end else if (bus.load) begin
      if (ld_ok) begin
        tens_next  = bus.ld_val[7:4];
        units_next = bus.ld_val[3:0];
      end else begin
        ld_err_next = 1'b1;
      end
    end else if (step) begin
      wrap_next = adj_wrap;
`ifdef DIV3_CNT_SAT_EN
      if (!adj_wrap) begin
        units_next = adj_units;
        tens_next  = adj_tens;
        tick_next  = 1'b1;
      end
`else
      units_next = adj_units;
      tens_next  = adj_tens;
      tick_next  = 1'b1;
`endif
    end
  end

  // fdclk_q resets high to mirror the divider, suppressing a step on the first edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fdclk_q_reg <= 1'b1;
      units_reg   <= 4'd0;
      tens_reg    <= 4'd0;
      tick_reg    <= 1'b0;
      wrap_reg    <= 1'b0;
      ld_err_reg  <= 1'b0;
    end else begin
      fdclk_q_reg <= bus.fdclk;
      units_reg   <= units_next;
      tens_reg    <= tens_next;
      tick_reg    <= tick_next;
      wrap_reg    <= wrap_next;
      ld_err_reg  <= ld_err_next;
    end
  end

  assign bus.cnt    = {tens_reg, units_reg};
  assign bus.tick   = tick_reg;
  assign bus.wrap   = wrap_reg;
  assign bus.ld_err = ld_err_reg;

endmodule

// File: tb/tb_div3_bcd_counter.sv
// Directed self-checking bench for div3_bcd_counter (both default and DIV3_CNT_SAT_EN builds).
`timescale 1ns/1ps

module tb_div3_bcd_counter;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  div3_bcd_counter_if bus ();

  div3_bcd_counter dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  // One cycle with fdclk high, then fdclk left low for the following cycles.
  task automatic step_edge();
    bus.fdclk = 1'b1;
    cyc();
    bus.fdclk = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load   = 1'b1;
    bus.ld_val = v;
    cyc();
    bus.load   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] e_cnt, input logic e_tick,
                     input logic e_wrap, input logic e_err);
    $display("chk %s: cnt=%h tick=%b wrap=%b ld_err=%b", tag, bus.cnt, bus.tick, bus.wrap, bus.ld_err);
    checks = checks + 1;
    assert (bus.cnt === e_cnt) passed = passed + 1;
    else $error("FAIL %s cnt got %h expected %h", tag, bus.cnt, e_cnt);
    checks = checks + 1;
    assert (bus.tick === e_tick) passed = passed + 1;
    else $error("FAIL %s tick got %b expected %b", tag, bus.tick, e_tick);
    checks = checks + 1;
    assert (bus.wrap === e_wrap) passed = passed + 1;
    else $error("FAIL %s wrap got %b expected %b", tag, bus.wrap, e_wrap);
    checks = checks + 1;
    assert (bus.ld_err === e_err) passed = passed + 1;
    else $error("FAIL %s ld_err got %b expected %b", tag, bus.ld_err, e_err);
  endtask

  initial begin
    bus.fdclk  = 1'b1;
    bus.c_up   = 1'b1;
    bus.clr    = 1'b0;
    bus.load   = 1'b0;
    bus.ld_val = 8'h00;
    rst_b      = 1'b0;
    cyc();
    chk("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Release with fdclk high: no step on the first edge, then steady 1-in-3 stepping.
    rst_b = 1'b1;
    cyc();
    chk("first_edge_no_step", 8'h00, 1'b0, 1'b0, 1'b0);
    bus.fdclk = 1'b0;
    idle(2);
    chk("idle_after_release", 8'h00, 1'b0, 1'b0, 1'b0);
    step_edge();
    chk("step_01", 8'h01, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("tick_one_cycle", 8'h01, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("hold_01", 8'h01, 1'b0, 1'b0, 1'b0);
    step_edge();
    chk("step_02", 8'h02, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Up across the 59/00 boundary.
    do_load(8'h58);
    chk("load_58", 8'h58, 1'b0, 1'b0, 1'b0);
    cyc();
    step_edge();
    chk("up_59", 8'h59, 1'b1, 1'b0, 1'b0);
    idle(2);
    step_edge();
`ifdef DIV3_CNT_SAT_EN
    chk("up_sat_59", 8'h59, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("after_sat_up", 8'h59, 1'b0, 1'b0, 1'b0);
`else
    chk("up_wrap_00", 8'h00, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("after_wrap_up", 8'h00, 1'b0, 1'b0, 1'b0);
`endif
    cyc();

    // fdclk held high several cycles yields a single step.
    do_load(8'h20);
    bus.fdclk = 1'b1;
    cyc();
    chk("held_high_step", 8'h21, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("held_high_no_more", 8'h21, 1'b0, 1'b0, 1'b0);
    bus.fdclk = 1'b0;
    cyc();

    // Down with tens borrow, then down across 00.
    bus.c_up = 1'b0;
    do_load(8'h10);
    step_edge();
    chk("down_09", 8'h09, 1'b1, 1'b0, 1'b0);
    idle(2);
    do_load(8'h00);
    bus.c_up = 1'b1;
    cyc();
    chk("c_up_between_steps", 8'h00, 1'b0, 1'b0, 1'b0);
    bus.c_up = 1'b0;
    step_edge();
`ifdef DIV3_CNT_SAT_EN
    chk("down_sat_00", 8'h00, 1'b0, 1'b1, 1'b0);
`else
    chk("down_wrap_59", 8'h59, 1'b1, 1'b1, 1'b0);
`endif
    cyc();
    bus.c_up = 1'b1;

    // Invalid loads rejected.
    do_load(8'h25);
    chk("load_25", 8'h25, 1'b0, 1'b0, 1'b0);
    do_load(8'h6A);
    chk("bad_load_6A", 8'h25, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("ld_err_one_cycle_6A", 8'h25, 1'b0, 1'b0, 1'b0);
    do_load(8'h3C);
    chk("bad_load_3C", 8'h25, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("ld_err_one_cycle_3C", 8'h25, 1'b0, 1'b0, 1'b0);

    // Priority: clr > load > step.
    do_load(8'h42);
    chk("load_42", 8'h42, 1'b0, 1'b0, 1'b0);
    bus.clr    = 1'b1;
    bus.load   = 1'b1;
    bus.ld_val = 8'h17;
    bus.fdclk  = 1'b1;
    cyc();
    chk("clr_wins", 8'h00, 1'b0, 1'b0, 1'b0);
    bus.clr   = 1'b0;
    bus.load  = 1'b0;
    bus.fdclk = 1'b0;
    cyc();
    bus.load  = 1'b1;
    bus.fdclk = 1'b1;
    cyc();
    chk("load_wins_17", 8'h17, 1'b0, 1'b0, 1'b0);
    bus.load  = 1'b0;
    bus.fdclk = 1'b0;
    cyc();
    chk("step_discarded", 8'h17, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream with a load and step pending.
    do_load(8'h33);
    cyc();
    bus.fdclk  = 1'b1;
    bus.load   = 1'b1;
    bus.ld_val = 8'h44;
    rst_b      = 1'b0;
    #1;
    chk("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    cyc();
    rst_b    = 1'b1;
    bus.load = 1'b0;
    cyc();
    chk("no_tick_after_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    bus.fdclk = 1'b0;
    idle(2);
    step_edge();
    chk("resume_01", 8'h01, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("resume_tick_clear", 8'h01, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
